// File: rtl/spi_flash_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash reader.
package spi_flash_pkg;

  localparam logic [7:0]  CMD_READ      = 8'h03;
  localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
  localparam int unsigned DUMMY_BITS    = 8;
  localparam int unsigned WORD_BITS     = 32;

  // One-hot controller state
  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_SEND    = 5'b00010,
    ST_DUMMY   = 5'b00100,
    ST_RECV    = 5'b01000,
    ST_RECOVER = 5'b10000
  } state_e;

  // First received byte lands in the least significant byte
  function automatic logic [WORD_BITS-1:0] le_word(input logic [WORD_BITS-1:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled,
// held low and phase-reset while disabled. Strobes flag the clk edge on
// which SCK is about to rise or fall.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic sck_o,
  output logic rise_en_c_o,
  output logic fall_en_c_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             edge_c;

  // Half-period counter and SCK toggle
  always_comb begin
    cnt_d  = '0;
    sck_d  = 1'b0;
    edge_c = en_i && (cnt_q == CNT_LAST);
    if (en_i) begin
      if (edge_c) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        sck_d = sck_q;
      end
    end
  end

  // Divider registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o       = sck_q;
  assign rise_en_c_o = edge_c & ~sck_q;
  assign fall_en_c_o = edge_c &  sck_q;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash burst read controller (mode 0). Issues one read command per
// request and streams 1..2^BURST_WIDTH little-endian words.
// Build option: define SPI_FLASH_FAST_READ_EN for fast read (0x0B) with
// 8 dummy SCK cycles; otherwise plain read (0x03).
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned BURST_WIDTH = 4,
  parameter int unsigned CLK_DIV     = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rstrb,
  input  logic [ADDR_WIDTH-1:0]  word_address,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic [WORD_BITS-1:0]   rdata,
  output logic                   rvalid,
  output logic                   rbusy,
  output logic                   spi_clk,
  output logic                   spi_cs_n,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam bit FAST_READ = 1'b1;
`else
  localparam bit FAST_READ = 1'b0;
`endif

  localparam logic [7:0]  CMD        = FAST_READ ? CMD_FAST_READ : CMD_READ;
  localparam int unsigned BIT_W      = $clog2(WORD_BITS);
  localparam int unsigned REC_CYCLES = 2 * CLK_DIV;
  localparam int unsigned REC_W      = $clog2(REC_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [WORD_BITS-1:0]   tx_q, tx_d;
  logic [WORD_BITS-1:0]   rx_q, rx_d;
  logic [WORD_BITS-1:0]   rdata_q, rdata_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [BURST_WIDTH-1:0] words_q, words_d;
  logic [REC_W-1:0]       rec_q, rec_d;
  logic                   cs_n_q, cs_n_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rbusy_q, rbusy_d;
  logic                   sck_en_c, sck, rise_en_c, fall_en_c;
  logic [23:0]            byte_addr_c;

  assign byte_addr_c = 24'({word_address, 2'b00});
  assign sck_en_c    = (state_q == ST_SEND) || (state_q == ST_DUMMY) || (state_q == ST_RECV);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_i        (sck_en_c),
    .sck_o       (sck),
    .rise_en_c_o (rise_en_c),
    .fall_en_c_o (fall_en_c)
  );

  // Next-state and datapath: MOSI shifts on SCK fall, MISO samples on SCK rise
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    bit_d    = bit_q;
    words_d  = words_q;
    rec_d    = rec_q;
    cs_n_d   = cs_n_q;
    rvalid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        if (rstrb) begin
          state_d = ST_SEND;
          tx_d    = {CMD, byte_addr_c};
          words_d = burst_len;
          bit_d   = '0;
          cs_n_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (fall_en_c) begin
          tx_d  = {tx_q[WORD_BITS-2:0], 1'b0};
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(WORD_BITS - 1)) begin
            bit_d = '0;
            if (FAST_READ) state_d = ST_DUMMY;
            else           state_d = ST_RECV;
          end
        end
      end
      ST_DUMMY: begin
        if (fall_en_c) begin
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DUMMY_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (rise_en_c) begin
          rx_d = {rx_q[WORD_BITS-2:0], spi_miso};
        end
        if (fall_en_c) begin
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(WORD_BITS - 1)) begin
            rdata_d  = le_word(rx_q);
            rvalid_d = 1'b1;
            if (words_q == '0) begin
              state_d = ST_RECOVER;
              rec_d   = '0;
            end else begin
              words_d = words_q - BURST_WIDTH'(1);
            end
          end
        end
      end
      ST_RECOVER: begin
        cs_n_d = 1'b1;
        rec_d  = rec_q + REC_W'(1);
        if (rec_q == REC_W'(REC_CYCLES)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
      end
    endcase

    rbusy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      bit_q    <= '0;
      words_q  <= '0;
      rec_q    <= '0;
      cs_n_q   <= 1'b1;
      rvalid_q <= 1'b0;
      rbusy_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      bit_q    <= bit_d;
      words_q  <= words_d;
      rec_q    <= rec_d;
      cs_n_q   <= cs_n_d;
      rvalid_q <= rvalid_d;
      rbusy_q  <= rbusy_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign rbusy    = rbusy_q;
  assign spi_clk  = sck;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = tx_q[WORD_BITS-1];

endmodule
